frame_config_loader: RTL and testbench
======================================

// Module: frame_config_loader
// PURPOSE
//  Configuration writer for the tile array. Takes a 32-bit bitstream word stream, decodes sync/header/data words
//  and drives the FrameData / FrameStrobe lines that tile ConfigMems latch. Sits at the fabric edge between the
//  bitstream source (UART/SPI/host bridge) and the column FrameStrobe / row FrameData inputs of the tile array.
// PARAMETERS
//  FrameBitsPerRow  32           width of s_data and FrameData; must equal 32
//  MaxFramesPerCol  20           frames per column; header frame index legal range 0..MaxFramesPerCol-1
//  NumColumns       8            columns addressed; header column index legal range 0..NumColumns-1
//  SyncWord         32'hFAB0FAB1 word that enters frame mode from IDLE
// PORTS
//  UserCLK       in   1                           the one clock; all state on rising edge
//  resetn        in   1                           asynchronous, active-low reset
//  s_data        in   FrameBitsPerRow             bitstream word
//  s_valid       in   1                           s_data valid
//  s_ready       out  1                           loader accepts word when s_valid & s_ready
//  FrameData     out  FrameBitsPerRow             frame word broadcast to all rows
//  FrameStrobe   out  NumColumns*MaxFramesPerCol  column c frame f at bit c*MaxFramesPerCol+f; at most one bit high
//  busy          out  1                           high in any state except IDLE
//  err           out  1                           sticky: illegal header seen
//  frames_written out 16                          count of strobes issued, wraps at 16'hFFFF->0
// BEHAVIOUR
//  Reset (async, resetn=0): state=IDLE, FrameData=0, FrameStrobe=0, s_ready=0 while asserted, busy=0, err=0,
//   frames_written=0. Reset mid-frame aborts with no strobe; a strobe in flight is cleared immediately.
//  States: IDLE, HEADER, DATA, STROBE, HOLD. s_ready=1 in IDLE/HEADER/DATA, 0 in STROBE/HOLD (first cycle after reset release: IDLE).
//  IDLE: accepted word==SyncWord -> HEADER; any other word consumed and discarded. err untouched by non-sync words.
//   Accepting SyncWord clears err.
//  HEADER word: [31]=desync, [23:16]=column, [7:0]=frame; other bits ignored.
//   desync=1 -> IDLE (column/frame ignored).
//   column>=NumColumns or frame>=MaxFramesPerCol -> err<=1, latch drop flag, -> DATA.
//   else latch column/frame, clear drop flag, -> DATA.
//  DATA word: if drop flag -> word discarded, FrameData unchanged, -> HEADER.
//   else FrameData<=s_data on acceptance edge, -> STROBE.
//  STROBE: exactly one cycle, FrameStrobe bit (col*MaxFramesPerCol+frame) =1, FrameData stable; frames_written+1; -> HOLD.
//  HOLD: one cycle, FrameStrobe=0, FrameData still stable (latch hold time); -> HEADER.
//  FrameStrobe is a registered output; FrameData changes only on a DATA acceptance edge, never during STROBE/HOLD.
//  Latency: DATA accept at edge N -> FrameData valid after N, strobe high N+1..N+2 (one cycle), next word accepted edge N+3.
//  Throughput with s_valid held high: 4 cycles/frame (header, data, strobe, hold).
//  s_valid low in any state with s_ready=1: state holds, outputs hold.
//  Index arithmetic: strobe index computed with width clog2(NumColumns*MaxFramesPerCol); only legal indices reach it.
//  busy=0 only in IDLE. No timeout: a stalled stream leaves the loader waiting in HEADER/DATA.
// TESTING
//  1 Reset release, feed SyncWord, header col=2 frame=5, data 32'hDEADBEEF -> FrameData=DEADBEEF, bit 45 of
//    FrameStrobe high exactly one cycle, frames_written=1, s_ready low 2 cycles, no other strobe bit ever set.
//  2 Burst: sync + 3 header/data pairs with s_valid held 1, then desync header 32'h8000_0000 -> three single-cycle
//    strobes 4 cycles apart, FrameData stable across each strobe+hold, busy=0 and IDLE after desync.
//  3 Illegal headers col=8 frame=0 and col=0 frame=20 each followed by data -> err=1, no strobe, data ignored,
//    next legal pair strobes normally; new SyncWord clears err.
//  4 Pre-sync garbage (32'h0, 32'h12345678) then SyncWord -> no strobes from garbage, loader enters HEADER.
//  5 Random s_valid gaps (30% idle) over 100 random legal frames -> strobe sequence and FrameData match model.
//  6 resetn asserted during STROBE -> FrameStrobe=0 asynchronously, all outputs at reset values, next frame needs sync.

Source files
------------

// File: rtl/frame_config_loader.sv
// rtl/frame_config_loader.sv - bitstream word decoder driving tile FrameData / FrameStrobe lines
//
// Takes 32-bit bitstream words over a valid/ready handshake. It waits for SyncWord, then decodes
// header/data word pairs. Each legal pair is loaded into FrameData and one FrameStrobe bit is pulsed
// for the addressed column/frame.
//
// Ports:
//   UserCLK        in   clock, all state on rising edge
//   resetn         in   asynchronous active-low reset
//   s_data         in   bitstream word
//   s_valid        in   s_data valid
//   s_ready        out  word accepted when s_valid & s_ready
//   FrameData      out  frame word broadcast to all rows
//   FrameStrobe    out  one-hot (or zero) strobe, bit col*MaxFramesPerCol+frame
//   busy           out  high whenever not waiting for sync
//   err            out  sticky illegal-header flag, cleared by the next SyncWord
//   frames_written out  wrapping count of strobes issued
module frame_config_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumColumns      = 8,
  parameter logic [31:0] SyncWord        = 32'hFAB0FAB1
) (
  input  logic                                  UserCLK,
  input  logic                                  resetn,
  input  logic [FrameBitsPerRow-1:0]            s_data,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  output logic [FrameBitsPerRow-1:0]            FrameData,
  output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
  output logic                                  busy,
  output logic                                  err,
  output logic [15:0]                           frames_written
);

  localparam int NumStrobes = NumColumns * MaxFramesPerCol;
  localparam int IdxW       = $clog2(NumStrobes);
  localparam int ColW       = (NumColumns > 1) ? $clog2(NumColumns) : 1;
  localparam int FrmW       = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_HEADER = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STROBE = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

  logic [2:0]                 r_state;
  logic [ColW-1:0]            r_col;
  logic [FrmW-1:0]            r_frame;
  logic                       r_drop;
  logic [FrameBitsPerRow-1:0] r_data;
  logic [NumStrobes-1:0]      r_strobe;
  logic                       r_err;
  logic [15:0]                r_count;

  logic                  w_accept;
  logic                  w_state_ready;
  logic [7:0]            w_hdr_col;
  logic [7:0]            w_hdr_frame;
  logic                  w_hdr_bad;
  logic [IdxW-1:0]       w_idx;
  logic [NumStrobes-1:0] w_onehot;

  // Ready is forced low while reset is held, independent of the state register.
  assign w_state_ready = (r_state == ST_IDLE) || (r_state == ST_HEADER) || (r_state == ST_DATA);
  assign s_ready       = resetn & w_state_ready;
  assign w_accept      = s_valid & s_ready;

  assign w_hdr_col   = s_data[23:16];
  assign w_hdr_frame = s_data[7:0];
  assign w_hdr_bad   = (w_hdr_col >= 8'(NumColumns)) || (w_hdr_frame >= 8'(MaxFramesPerCol));

  // Only headers that passed the range check are latched, so w_idx is always below NumStrobes.
  assign w_idx = IdxW'(r_col) * IdxW'(MaxFramesPerCol) + IdxW'(r_frame);

  always_comb begin
    w_onehot        = '0;
    w_onehot[w_idx] = 1'b1;
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_IDLE;
      r_col    <= '0;
      r_frame  <= '0;
      r_drop   <= 1'b0;
      r_data   <= '0;
      r_strobe <= '0;
      r_err    <= 1'b0;
      r_count  <= 16'd0;
    end else begin
      r_strobe <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (s_data == SyncWord)) begin
            r_state <= ST_HEADER;
            r_err   <= 1'b0;
          end
        end
        ST_HEADER: begin
          if (w_accept) begin
            if (s_data[31]) begin
              r_state <= ST_IDLE;
            end else if (w_hdr_bad) begin
              // The following data word is still consumed, but it is discarded.
              r_err   <= 1'b1;
              r_drop  <= 1'b1;
              r_state <= ST_DATA;
            end else begin
              r_col   <= s_data[16 +: ColW];
              r_frame <= s_data[0 +: FrmW];
              r_drop  <= 1'b0;
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            if (r_drop) begin
              r_state <= ST_HEADER;
            end else begin
              r_data  <= s_data;
              r_state <= ST_STROBE;
            end
          end
        end
        ST_STROBE: begin
          // The registered strobe is visible during the following (HOLD) cycle.
          // FrameData has already been stable for a full cycle by then.
          r_strobe <= w_onehot;
          r_count  <= r_count + 16'd1;
          r_state  <= ST_HOLD;
        end
        ST_HOLD: begin
          r_state <= ST_HEADER;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign FrameData      = r_data;
  assign FrameStrobe    = r_strobe;
  assign busy           = (r_state != ST_IDLE);
  assign err            = r_err;
  assign frames_written = r_count;

endmodule

// File: tb/tb_frame_config_loader.sv
// tb/tb_frame_config_loader.sv - self-checking bench for frame_config_loader
module tb_frame_config_loader;

  localparam int          NC   = 8;
  localparam int          NF   = 20;
  localparam int          NS   = NC * NF;
  localparam logic [31:0] SYNC = 32'hFAB0FAB1;

  logic          UserCLK = 1'b0;
  logic          resetn  = 1'b0;
  logic [31:0]   s_data  = 32'd0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   FrameData;
  logic [NS-1:0] FrameStrobe;
  logic          busy;
  logic          err;
  logic [15:0]   frames_written;

  frame_config_loader #(
    .FrameBitsPerRow(32),
    .MaxFramesPerCol(NF),
    .NumColumns(NC),
    .SyncWord(SYNC)
  ) dut (
    .UserCLK(UserCLK),
    .resetn(resetn),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .FrameData(FrameData),
    .FrameStrobe(FrameStrobe),
    .busy(busy),
    .err(err),
    .frames_written(frames_written)
  );

  always #5 UserCLK = ~UserCLK;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] data;
    int          cyc;
  } strobe_t;

  // Word-level reference model. Mode: 0 waiting for sync, 1 expecting header, 2 expecting data.
  int          cyc = 0;
  int          m_mode;
  bit          m_drop;
  int          m_idx;
  logic [31:0] m_fd;
  bit          m_err;
  int          m_fw;
  int          m_rs;
  int          m_re;
  strobe_t     exp_q[$];

  int fd_bad = 0, busy_bad = 0, err_bad = 0, rdy_bad = 0;
  int strobe_bad = 0, strobe_seen = 0;
  int obs_cyc[$];
  int last_idx = -1;

  always @(posedge UserCLK) begin
    cyc++;
    if (!resetn) begin
      m_mode = 0; m_drop = 0; m_idx = 0; m_fd = 32'd0; m_err = 0; m_fw = 0;
      m_rs = 0; m_re = 0;
      exp_q.delete();
    end else if (s_valid && s_ready) begin
      if (m_mode == 0) begin
        if (s_data == SYNC) begin m_mode = 1; m_err = 0; end
      end else if (m_mode == 1) begin
        if (s_data[31]) m_mode = 0;
        else begin
          m_mode = 2;
          if (int'(s_data[23:16]) >= NC || int'(s_data[7:0]) >= NF) begin
            m_err = 1; m_drop = 1;
          end else begin
            m_drop = 0;
            m_idx  = int'(s_data[23:16]) * NF + int'(s_data[7:0]);
          end
        end
      end else begin
        m_mode = 1;
        if (!m_drop) begin
          m_fd = s_data;
          m_fw = (m_fw + 1) % 65536;
          exp_q.push_back('{idx: m_idx, data: s_data, cyc: cyc + 1});
          m_rs = cyc;
          m_re = cyc + 1;
        end
      end
    end
  end

  always @(negedge UserCLK) begin
    if (resetn) begin
      if (FrameData !== m_fd) fd_bad++;
      if (busy !== (m_mode != 0)) busy_bad++;
      if (err !== m_err) err_bad++;
      if (s_ready !== !(cyc >= m_rs && cyc <= m_re)) rdy_bad++;
      if (FrameStrobe != '0) begin
        strobe_t e;
        strobe_seen++;
        obs_cyc.push_back(cyc);
        for (int b = 0; b < NS; b++) if (FrameStrobe[b]) last_idx = b;
        if ($countones(FrameStrobe) != 1 || exp_q.size() == 0) strobe_bad++;
        else begin
          e = exp_q.pop_front();
          if (!FrameStrobe[e.idx] || FrameData !== e.data || cyc != e.cyc) strobe_bad++;
        end
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge UserCLK);
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      @(negedge UserCLK);
      n++;
    end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL send_word_timeout got=s_ready_low want=accept word=%h", w);
    end
    @(posedge UserCLK);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge UserCLK);
      s_valid = 1'b0;
      s_data  = $urandom;
    end
  endtask

  task automatic clear_monitor();
    fd_bad = 0; busy_bad = 0; err_bad = 0; rdy_bad = 0;
    strobe_bad = 0; strobe_seen = 0; obs_cyc.delete();
  endtask

  function automatic logic [31:0] hdr(input int col, input int frm);
    hdr = {1'b0, 7'($urandom), 8'(col), 8'($urandom), 8'(frm)};
  endfunction

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge UserCLK);
    checks++;
    if ({FrameData, FrameStrobe, s_ready, busy, err, frames_written} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got fd=%h st=%h rdy=%b busy=%b err=%b fw=%0d want=all_zero",
               FrameData, FrameStrobe, s_ready, busy, err, frames_written);
    end
    resetn = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got rdy=%b busy=%b want rdy=1 busy=0", s_ready, busy);
    end
    clear_monitor();
  endtask

  task automatic test_single_frame();
    clear_monitor();
    send_word(SYNC);
    send_word(32'h0002_0005);
    send_word(32'hDEADBEEF);
    idle_cycles(6);
    checks++;
    if (strobe_seen != 1 || strobe_bad != 0 || exp_q.size() != 0 || last_idx != 45) begin
      failures++;
      $display("FAIL single_strobe got seen=%0d bad=%0d pend=%0d idx=%0d want seen=1 bad=0 pend=0 idx=45",
               strobe_seen, strobe_bad, exp_q.size(), last_idx);
    end
    checks++;
    if (FrameData !== 32'hDEADBEEF || frames_written !== 16'd1) begin
      failures++;
      $display("FAIL single_data got fd=%h fw=%0d want fd=deadbeef fw=1", FrameData, frames_written);
    end
    checks++;
    if (rdy_bad != 0 || fd_bad != 0 || busy_bad != 0) begin
      failures++;
      $display("FAIL single_timing got rdy_bad=%0d fd_bad=%0d busy_bad=%0d want 0",
               rdy_bad, fd_bad, busy_bad);
    end
  endtask

  task automatic test_back_to_back();
    clear_monitor();
    for (int i = 0; i < 3; i++) begin
      send_word(hdr($urandom_range(NC - 1), $urandom_range(NF - 1)));
      send_word($urandom);
    end
    send_word(32'h8000_0000);
    idle_cycles(2);
    checks++;
    if (strobe_seen != 3 || strobe_bad != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL burst_strobes got seen=%0d bad=%0d pend=%0d want seen=3 bad=0 pend=0",
               strobe_seen, strobe_bad, exp_q.size());
    end
    checks++;
    if (obs_cyc.size() != 3 || obs_cyc[1] - obs_cyc[0] != 4 || obs_cyc[2] - obs_cyc[1] != 4) begin
      failures++;
      $display("FAIL burst_spacing got n=%0d want 3 strobes 4 cycles apart", obs_cyc.size());
    end
    checks++;
    if (busy !== 1'b0 || fd_bad != 0 || rdy_bad != 0 || busy_bad != 0) begin
      failures++;
      $display("FAIL burst_desync got busy=%b fd_bad=%0d rdy_bad=%0d busy_bad=%0d want 0",
               busy, fd_bad, rdy_bad, busy_bad);
    end
  endtask

  task automatic test_illegal_header();
    clear_monitor();
    send_word(SYNC);
    send_word(32'h0008_0000);
    send_word($urandom);
    send_word(32'h0000_0014);
    send_word($urandom);
    idle_cycles(2);
    checks++;
    if (err !== 1'b1 || strobe_seen != 0) begin
      failures++;
      $display("FAIL illegal_err got err=%b strobes=%0d want err=1 strobes=0", err, strobe_seen);
    end
    send_word(hdr(7, 19));
    send_word(32'hA5A5_0F0F);
    idle_cycles(4);
    checks++;
    if (strobe_seen != 1 || strobe_bad != 0 || last_idx != 159 || FrameData !== 32'hA5A5_0F0F) begin
      failures++;
      $display("FAIL illegal_recover got seen=%0d bad=%0d idx=%0d fd=%h want 1 0 159 a5a50f0f",
               strobe_seen, strobe_bad, last_idx, FrameData);
    end
    send_word(32'h8000_0000);
    send_word(SYNC);
    idle_cycles(1);
    checks++;
    if (err !== 1'b0 || err_bad != 0 || fd_bad != 0) begin
      failures++;
      $display("FAIL illegal_clear got err=%b err_bad=%0d fd_bad=%0d want 0 0 0", err, err_bad, fd_bad);
    end
    send_word(32'h8000_0000);
  endtask

  task automatic test_garbage();
    clear_monitor();
    send_word(32'h0000_0000);
    send_word(32'h1234_5678);
    idle_cycles(2);
    checks++;
    if (busy !== 1'b0 || strobe_seen != 0) begin
      failures++;
      $display("FAIL garbage_idle got busy=%b strobes=%0d want busy=0 strobes=0", busy, strobe_seen);
    end
    send_word(SYNC);
    idle_cycles(1);
    checks++;
    if (busy !== 1'b1 || s_ready !== 1'b1 || busy_bad != 0) begin
      failures++;
      $display("FAIL garbage_sync got busy=%b rdy=%b busy_bad=%0d want 1 1 0", busy, s_ready, busy_bad);
    end
    send_word(32'h8000_0000);
  endtask

  task automatic test_random_gaps();
    clear_monitor();
    send_word(SYNC);
    for (int i = 0; i < 100; i++) begin
      while ($urandom_range(99) < 30) idle_cycles(1);
      send_word(hdr($urandom_range(NC - 1), $urandom_range(NF - 1)));
      while ($urandom_range(99) < 30) idle_cycles(1);
      send_word($urandom);
    end
    idle_cycles(4);
    checks++;
    if (strobe_seen != 100 || strobe_bad != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_strobes got seen=%0d bad=%0d pend=%0d want seen=100 bad=0 pend=0",
               strobe_seen, strobe_bad, exp_q.size());
    end
    checks++;
    if (fd_bad != 0 || rdy_bad != 0 || busy_bad != 0 || err_bad != 0) begin
      failures++;
      $display("FAIL random_outputs got fd=%0d rdy=%0d busy=%0d err=%0d want all 0",
               fd_bad, rdy_bad, busy_bad, err_bad);
    end
    checks++;
    if (frames_written !== 16'(m_fw)) begin
      failures++;
      $display("FAIL random_count got=%0d want=%0d", frames_written, m_fw);
    end
    send_word(32'h8000_0000);
  endtask

  task automatic test_reset_mid_strobe();
    int n;
    clear_monitor();
    send_word(SYNC);
    send_word(hdr(3, 4));
    send_word(32'h0BAD_F00D);
    idle_cycles(1);
    n = 0;
    while (FrameStrobe == '0 && n < 10) begin
      @(negedge UserCLK);
      n++;
    end
    checks++;
    if (FrameStrobe == '0) begin
      failures++;
      $display("FAIL midreset_no_strobe got=0 want=strobe_high");
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({FrameData, FrameStrobe, s_ready, busy, err, frames_written} !== '0) begin
      failures++;
      $display("FAIL midreset_async got fd=%h st=%h rdy=%b busy=%b err=%b fw=%0d want=all_zero",
               FrameData, FrameStrobe, s_ready, busy, err, frames_written);
    end
    repeat (3) @(negedge UserCLK);
    resetn = 1'b1;
    clear_monitor();
    send_word(hdr(1, 1));
    send_word(32'h1111_2222);
    idle_cycles(4);
    checks++;
    if (strobe_seen != 0 || busy !== 1'b0 || fd_bad != 0) begin
      failures++;
      $display("FAIL midreset_needs_sync got strobes=%0d busy=%b fd_bad=%0d want 0 0 0",
               strobe_seen, busy, fd_bad);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    send_word(32'h8000_0000);
    test_back_to_back_entry();
    test_illegal_header();
    test_garbage();
    test_random_gaps();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic test_back_to_back_entry();
    send_word(SYNC);
    test_back_to_back();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
